// File: rtl/core_pkg.sv
// Shared types and constants for the register-file write-back path.
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of write-back entries; no fall-through, so a pushed entry is
// visible at the head only from the following cycle.
module wb_fifo
  import core_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wb_entry_t                    push_data,
  input  logic                         pop,
  output wb_entry_t                    pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  wb_entry_t             mem [Depth];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CntW'(Depth));
  assign empty    = (count_q == '0);

  a_no_overflow : assert property (@(posedge clk) disable iff (rst) push |-> (!full || pop));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst) pop |-> !empty);

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and load results onto the register file's single write port and
// tracks outstanding destination registers for decode's RAW stall checks.
module regfile_writeback
  import core_pkg::*;
#(
  parameter int unsigned LSU_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]       alu_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [REG_ADDR_W-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]       lsu_data_i,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o,
  output logic                  reg_wr_en_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]       wr_data_o
);

  localparam int unsigned CntW = $clog2(LSU_DEPTH + 1);

  wb_entry_t       lsu_entry, head;
  logic            push, pop, full, empty, alu_fire;
  logic [CntW-1:0] count;

  logic                  wr_en_d, wr_en_q;
  logic [REG_ADDR_W-1:0] rd_d, rd_q;
  logic [XLEN-1:0]       data_d, data_q;
  logic [NUM_REGS-1:0]   pending_d, pending_q;

  // Loads have priority: the ALU may only hand over a result once the buffer is drained.
  assign lsu_ready_o = !rst_i && !full;
  assign alu_ready_o = !rst_i && (count == '0);

  assign push      = lsu_valid_i && lsu_ready_o;
  assign pop       = !empty;
  assign alu_fire  = alu_valid_i && alu_ready_o;
  assign lsu_entry = '{rd: lsu_rd_i, data: lsu_data_i};

  wb_fifo #(
    .Depth (LSU_DEPTH)
  ) u_lsu_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (lsu_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    wr_en_d = 1'b0;
    rd_d    = rd_q;
    data_d  = data_q;
    if (!empty) begin
      wr_en_d = (head.rd != '0);
      rd_d    = head.rd;
      data_d  = head.data;
    end else if (alu_fire) begin
      wr_en_d = (alu_rd_i != '0);
      rd_d    = alu_rd_i;
      data_d  = alu_data_i;
    end
  end

  // A same-edge issue overrides the clear: the newer producer is still in flight.
  always_comb begin
    pending_d = pending_q;
    if (wr_en_d) pending_d[rd_d] = 1'b0;
    if (issue_valid_i && (issue_rd_i != '0)) pending_d[issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_en_q   <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      pending_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

  assign rs1_busy_o  = pending_q[rs1_addr_i];
  assign rs2_busy_o  = pending_q[rs2_addr_i];
  assign reg_wr_en_o = wr_en_q;
  assign rd_addr_o   = rd_q;
  assign wr_data_o   = data_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomised bench for regfile_writeback against a queue-based reference model.
module tb_regfile_writeback;
  import core_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic                  clk;
  logic                  rst;
  logic                  alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [REG_ADDR_W-1:0] alu_rd, lsu_rd, issue_rd, rs1_addr, rs2_addr, rd_addr;
  logic [XLEN-1:0]       alu_data, lsu_data, wr_data;
  logic                  issue_valid, rs1_busy, rs2_busy, reg_wr_en;

  regfile_writeback #(
    .LSU_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .alu_valid_i   (alu_valid),
    .alu_ready_o   (alu_ready),
    .alu_rd_i      (alu_rd),
    .alu_data_i    (alu_data),
    .lsu_valid_i   (lsu_valid),
    .lsu_ready_o   (lsu_ready),
    .lsu_rd_i      (lsu_rd),
    .lsu_data_i    (lsu_data),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .rs1_addr_i    (rs1_addr),
    .rs2_addr_i    (rs2_addr),
    .rs1_busy_o    (rs1_busy),
    .rs2_busy_o    (rs2_busy),
    .reg_wr_en_o   (reg_wr_en),
    .rd_addr_o     (rd_addr),
    .wr_data_o     (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: buffered loads as a queue, write port as a register, pending as an array.
  logic [REG_ADDR_W+XLEN-1:0] q[$];
  logic                       m_en;
  logic [REG_ADDR_W-1:0]      m_rd;
  logic [XLEN-1:0]            m_data;
  bit                         pend[NUM_REGS];

  task automatic model_reset();
    q.delete();
    m_en   = 1'b0;
    m_rd   = '0;
    m_data = '0;
    foreach (pend[i]) pend[i] = 1'b0;
  endtask

  // Drive one cycle of inputs, check combinational outputs, clock, check the write port.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic afire, lfire;
    logic [REG_ADDR_W+XLEN-1:0] e;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    issue_valid = iv; issue_rd = ird;
    rs1_addr = r1; rs2_addr = r2;
    assert (!(iv && ird != 0 && pend[ird])) else $error("bench issued a WAW write");
    #1;
    check("lsu_ready", lsu_ready, (!rst && q.size() < DEPTH));
    check("alu_ready", alu_ready, (!rst && q.size() == 0));
    check("rs1_busy", rs1_busy, (r1 != 0 && pend[r1]));
    check("rs2_busy", rs2_busy, (r2 != 0 && pend[r2]));
    afire = av && !rst && q.size() == 0;
    lfire = lv && !rst && q.size() < DEPTH;
    @(posedge clk);
    if (!rst) begin
      if (q.size() > 0) begin
        e      = q.pop_front();
        m_rd   = e[REG_ADDR_W+XLEN-1:XLEN];
        m_data = e[XLEN-1:0];
        m_en   = (m_rd != 0);
      end else if (afire) begin
        m_rd   = ard;
        m_data = ad;
        m_en   = (ard != 0);
      end else begin
        m_en = 1'b0;
      end
      if (m_en) pend[m_rd] = 1'b0;
      if (iv && ird != 0) pend[ird] = 1'b1;
      if (lfire) q.push_back({lrd, ld});
    end
    #1;
    check("wr_en", reg_wr_en, m_en);
    check("rd_addr", rd_addr, m_rd);
    check("wr_data", wr_data, m_data);
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, r1, r2);
  endtask

  initial begin
    logic av, lv, iv;
    logic [4:0] ird;
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
    model_reset();
    #2;
    check("rst_wr_en", reg_wr_en, 1'b0);
    check("rst_rd", rd_addr, 5'd0);
    check("rst_data", wr_data, 32'd0);
    check("rst_alu_ready", alu_ready, 1'b0);
    check("rst_lsu_ready", lsu_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ALU-only write, one cycle latency
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("alu_x5_en", reg_wr_en, 1'b1);
    check("alu_x5_rd", rd_addr, 5'd5);
    check("alu_x5_data", wr_data, 32'hDEADBEEF);

    // ALU and load together: ALU first, load next, ALU stalled while buffered
    step(1'b1, 5'd3, 32'hAAAA0003, 1'b1, 5'd4, 32'hBBBB0004, 1'b0, 5'd0, 5'd0, 5'd0);
    check("both_alu_rd", rd_addr, 5'd3);
    step(1'b1, 5'd6, 32'hCCCC0006, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("both_lsu_rd", rd_addr, 5'd4);
    check("both_lsu_data", wr_data, 32'hBBBB0004);
    step(1'b1, 5'd6, 32'hCCCC0006, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("stalled_alu_rd", rd_addr, 5'd6);

    // Back-to-back loads, then loads with the ALU held valid
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'(8 + i), $urandom, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 5'd12, 32'h12, 1'b1, 5'(13 + i), $urandom, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (2) idle(5'd0, 5'd0);

    // Scoreboard set, clear, and same-edge set-wins
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    check("sb_x7_set", rs1_busy, 1'b1);
    step(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    check("sb_x7_clear", rs1_busy, 1'b0);
    step(1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    check("sb_x7_setwins", rs1_busy, 1'b1);
    step(1'b1, 5'd7, 32'h79, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);

    // x0 results are consumed but never written; x0 never goes busy
    step(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    check("x0_wr_en", reg_wr_en, 1'b0);
    check("x0_busy", rs1_busy, 1'b0);

    // Reset mid-burst with a load buffered and a register pending
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd9, 5'd0, 5'd0);
    step(1'b1, 5'd11, 32'hB0, 1'b1, 5'd11, 32'hB1, 1'b0, 5'd0, 5'd9, 5'd11);
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    rst = 1'b1;
    #1;
    check("midrst_wr_en", reg_wr_en, 1'b0);
    check("midrst_alu_ready", alu_ready, 1'b0);
    check("midrst_lsu_ready", lsu_ready, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) idle(5'd9, 5'd11);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      av  = ($urandom_range(0, 1) == 1);
      lv  = ($urandom_range(0, 9) < 4);
      ird = 5'($urandom_range(0, 31));
      iv  = ($urandom_range(0, 9) < 3) && !pend[ird];
      step(av, 5'($urandom_range(0, 31)), $urandom, lv, 5'($urandom_range(0, 31)), $urandom,
           iv, ird, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
